// File: rtl/scan_display_drv.sv
// Four-digit 7-segment scan driver: follows a rotating one-hot phase strobe and drives digit enables and segments.
// It double-buffers the display data and flags out-of-order phases. Define SCAN_LZB_EN to enable leading-zero blanking.
module scan_display_drv #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       phase,
  input  logic             load,
  input  logic [15:0]      data,
  output logic [6:0]       seg,
  output logic [3:0]       dig,
  output logic             pending,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] PH_FRAME_START = 4'b1000;
  localparam logic [6:0] SEG_OFF        = 7'b0000000;

  logic [3:0]       exp_q, exp_d;
  logic             valid_q, valid_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      active_q, active_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       dig_q, dig_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic        one_hot;
  logic        fault;
  logic        commit;
  logic [15:0] disp_val;
  logic [3:0]  digit_val;
  logic        blank;

  function automatic logic is_one_hot(input logic [3:0] p);
    return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
  endfunction

  // The generator rotates right: 1000 -> 0100 -> 0010 -> 0001 -> 1000.
  function automatic logic [3:0] successor(input logic [3:0] p);
    return {p[0], p[3:1]};
  endfunction

  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Phase checking and commit decision.
  always_comb begin
    one_hot  = is_one_hot(phase);
    fault    = !one_hot || (valid_q && (phase != exp_q));
    commit   = !fault && (phase == PH_FRAME_START) && pending_q;
    // The committing cycle already shows the new data.
    disp_val = commit ? shadow_q : active_q;
  end

  // Digit selection; non-one-hot phases fall into the default and are masked by fault.
  always_comb begin
    case (phase)
      4'b1000: digit_val = disp_val[15:12];
      4'b0100: digit_val = disp_val[11:8];
      4'b0010: digit_val = disp_val[7:4];
      default: digit_val = disp_val[3:0];
    endcase
  end

`ifdef SCAN_LZB_EN
  // A digit blanks only when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    case (phase)
      4'b1000: blank = (disp_val[15:12] == 4'h0);
      4'b0100: blank = (disp_val[15:8] == 8'h00);
      4'b0010: blank = (disp_val[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default before any
  // conditional update, so no path leaves a value held and no latch is inferred.
  always_comb begin
    seg_d     = SEG_OFF;
    dig_d     = 4'b0000;
    seq_err_d = fault;
    err_cnt_d = err_cnt_q;
    exp_d     = exp_q;
    valid_d   = one_hot;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (fault) begin
      if (err_cnt_q != {ERR_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end else begin
      dig_d = phase;
      if (!blank) begin
        seg_d = decode7(digit_val);
      end
    end

    if (one_hot) begin
      exp_d = successor(phase);
    end

    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // A load in the commit cycle queues the next value behind the one just committed.
    if (load) begin
      shadow_d  = data;
      pending_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= 4'b0000;
      valid_q   <= 1'b0;
      shadow_q  <= 16'h0000;
      active_q  <= 16'h0000;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= 4'b0000;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      exp_q     <= exp_d;
      valid_q   <= valid_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign seg     = seg_q;
  assign dig     = dig_q;
  assign pending = pending_q;
  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_scan_display_drv.sv
// Self-checking bench for scan_display_drv: a directed vector table, then randomized phase/load traffic checked
// against a digit-position reference model. A second instance with ERR_W=2 exercises counter saturation.
module tb_scan_display_drv;

  logic        clk;
  logic        rst_n;
  logic [3:0]  phase;
  logic        load;
  logic [15:0] data;
  logic [6:0]  seg, seg_s;
  logic [3:0]  dig, dig_s;
  logic        pending, pending_s;
  logic        seq_err, seq_err_s;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt_s;

  int n_cmp = 0;
  int n_bad = 0;

  scan_display_drv #(.ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .phase(phase), .load(load), .data(data),
    .seg(seg), .dig(dig), .pending(pending), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  scan_display_drv #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .phase(phase), .load(load), .data(data),
    .seg(seg_s), .dig(dig_s), .pending(pending_s), .seq_err(seq_err_s), .err_cnt(err_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment table straight from the digit-to-pattern list; 10..15 show a dash.
  logic [6:0] lut [16];
  initial begin
    lut[0] = 7'b1111110; lut[1] = 7'b0110000; lut[2] = 7'b1101101; lut[3] = 7'b1111001;
    lut[4] = 7'b0110011; lut[5] = 7'b1011011; lut[6] = 7'b1011111; lut[7] = 7'b1110000;
    lut[8] = 7'b1111111; lut[9] = 7'b1111011;
    for (int i = 10; i < 16; i++) lut[i] = 7'b0000001;
  end

`ifdef SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Reference model state.
  bit          m_valid;
  int          m_exp_pos;
  logic [15:0] m_shadow, m_active;
  bit          m_pending;
  int          m_errs;
  logic [6:0]  e_seg;
  logic [3:0]  e_dig;
  bit          e_serr;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_exp_pos = 0; m_shadow = '0; m_active = '0;
    m_pending = 0; m_errs = 0; e_seg = '0; e_dig = '0; e_serr = 0;
  endtask

  // Digit positions: bit k of phase selects digit k; the next phase is position k-1, wrapping 0 -> 3.
  task automatic model_step(input logic [3:0] ph, input logic ld, input logic [15:0] d);
    int pos, val, upper;
    bit oh, flt, cmt;
    logic [15:0] shown;
    pos = -1;
    oh = ($countones(ph) == 1);
    for (int k = 0; k < 4; k++) if (ph[k]) pos = k;
    flt = !oh || (m_valid && pos != m_exp_pos);
    cmt = !flt && pos == 3 && m_pending;
    shown = cmt ? m_shadow : m_active;
    e_serr = flt;
    if (flt) begin
      m_errs++;
      e_seg = '0;
      e_dig = '0;
    end else begin
      val   = (int'(shown) >> (4 * pos)) % 16;
      upper = int'(shown) >> (4 * pos);
      e_dig = ph;
      e_seg = (LZB && pos > 0 && upper == 0) ? 7'b0 : lut[val];
    end
    if (oh) begin
      m_valid = 1;
      m_exp_pos = (pos + 3) % 4;
    end else begin
      m_valid = 0;
    end
    if (cmt) begin
      m_active = m_shadow;
      m_pending = 0;
    end
    if (ld) begin
      m_shadow = d;
      m_pending = 1;
    end
  endtask

  // Drive on the falling edge, let the rising edge sample, compare on the next falling edge.
  task automatic apply(input logic [3:0] ph, input logic ld, input logic [15:0] d);
    phase = ph; load = ld; data = d;
    model_step(ph, ld, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    phase = 4'b0000; load = 1'b0; data = 16'h0;
    #3;
    model_reset();
    check("reset seg", 32'(seg), 32'h0);
    check("reset dig", 32'(dig), 32'h0);
    check("reset pending", 32'(pending), 32'h0);
    check("reset seq_err", 32'(seq_err), 32'h0);
    check("reset err_cnt", 32'(err_cnt), 32'h0);
    check("reset err_cnt_sat", 32'(err_cnt_s), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " seg"}, 32'(seg), 32'(e_seg));
    check({tag, " dig"}, 32'(dig), 32'(e_dig));
    check({tag, " pending"}, 32'(pending), 32'(m_pending));
    check({tag, " seq_err"}, 32'(seq_err), 32'(e_serr));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(sat(m_errs, 255)));
    check({tag, " err_cnt_sat"}, 32'(err_cnt_s), 32'(sat(m_errs, 3)));
  endtask

  typedef struct {
    logic [3:0]  ph;
    logic        ld;
    logic [15:0] d;
    logic [6:0]  seg;
    logic [6:0]  seg_lzb;
    logic [3:0]  dig;
    logic        pend;
    logic        serr;
    int          ecnt;
  } vec_t;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
  localparam logic [6:0] S9 = 7'b1111011, SD = 7'b0000001, SX = 7'b0000000;

  vec_t vt [39];

  initial begin
    logic [3:0] ph;
    logic       ld;
    logic [15:0] d;
    logic [6:0] want_seg;

    //          ph       ld  data      seg  seg_lzb dig     pend serr ecnt
    vt[0]  = '{4'b1000, 0, 16'h0000, S0, SX, 4'b1000, 0, 0, 0};
    vt[1]  = '{4'b0100, 1, 16'h1234, S0, SX, 4'b0100, 1, 0, 0};
    vt[2]  = '{4'b0010, 0, 16'h0000, S0, SX, 4'b0010, 1, 0, 0};
    vt[3]  = '{4'b0001, 0, 16'h0000, S0, S0, 4'b0001, 1, 0, 0};
    vt[4]  = '{4'b1000, 0, 16'h0000, S1, S1, 4'b1000, 0, 0, 0};
    vt[5]  = '{4'b0100, 0, 16'h0000, S2, S2, 4'b0100, 0, 0, 0};
    vt[6]  = '{4'b0010, 0, 16'h0000, S3, S3, 4'b0010, 0, 0, 0};
    vt[7]  = '{4'b0001, 0, 16'h0000, S4, S4, 4'b0001, 0, 0, 0};
    vt[8]  = '{4'b1000, 0, 16'h0000, S1, S1, 4'b1000, 0, 0, 0};
    vt[9]  = '{4'b0100, 0, 16'h0000, S2, S2, 4'b0100, 0, 0, 0};
    vt[10] = '{4'b0001, 0, 16'h0000, SX, SX, 4'b0000, 0, 1, 1};
    vt[11] = '{4'b1000, 0, 16'h0000, S1, S1, 4'b1000, 0, 0, 1};
    vt[12] = '{4'b0000, 0, 16'h0000, SX, SX, 4'b0000, 0, 1, 2};
    vt[13] = '{4'b1100, 0, 16'h0000, SX, SX, 4'b0000, 0, 1, 3};
    vt[14] = '{4'b0010, 0, 16'h0000, S3, S3, 4'b0010, 0, 0, 3};
    vt[15] = '{4'b0001, 0, 16'h0000, S4, S4, 4'b0001, 0, 0, 3};
    vt[16] = '{4'b1000, 1, 16'h1111, S1, S1, 4'b1000, 1, 0, 3};
    vt[17] = '{4'b0100, 0, 16'h0000, S2, S2, 4'b0100, 1, 0, 3};
    vt[18] = '{4'b0010, 0, 16'h0000, S3, S3, 4'b0010, 1, 0, 3};
    vt[19] = '{4'b0001, 0, 16'h0000, S4, S4, 4'b0001, 1, 0, 3};
    vt[20] = '{4'b1000, 1, 16'h2222, S1, S1, 4'b1000, 1, 0, 3};
    vt[21] = '{4'b0100, 0, 16'h0000, S1, S1, 4'b0100, 1, 0, 3};
    vt[22] = '{4'b0010, 0, 16'h0000, S1, S1, 4'b0010, 1, 0, 3};
    vt[23] = '{4'b0001, 0, 16'h0000, S1, S1, 4'b0001, 1, 0, 3};
    vt[24] = '{4'b1000, 0, 16'h0000, S2, S2, 4'b1000, 0, 0, 3};
    vt[25] = '{4'b0100, 0, 16'h0000, S2, S2, 4'b0100, 0, 0, 3};
    vt[26] = '{4'b0010, 1, 16'h0A05, S2, S2, 4'b0010, 1, 0, 3};
    vt[27] = '{4'b0001, 0, 16'h0000, S2, S2, 4'b0001, 1, 0, 3};
    vt[28] = '{4'b1000, 0, 16'h0000, S0, SX, 4'b1000, 0, 0, 3};
    vt[29] = '{4'b0100, 0, 16'h0000, SD, SD, 4'b0100, 0, 0, 3};
    vt[30] = '{4'b0010, 0, 16'h0000, S0, S0, 4'b0010, 0, 0, 3};
    vt[31] = '{4'b0001, 0, 16'h0000, S5, S5, 4'b0001, 0, 0, 3};
    vt[32] = '{4'b1000, 1, 16'h9999, S0, SX, 4'b1000, 1, 0, 3};
    vt[33] = '{4'b0100, 0, 16'h0000, SD, SD, 4'b0100, 1, 0, 3};
    vt[34] = '{4'b1000, 0, 16'h0000, SX, SX, 4'b0000, 1, 1, 4};
    vt[35] = '{4'b0100, 0, 16'h0000, SD, SD, 4'b0100, 1, 0, 4};
    vt[36] = '{4'b0010, 0, 16'h0000, S0, S0, 4'b0010, 1, 0, 4};
    vt[37] = '{4'b0001, 0, 16'h0000, S5, S5, 4'b0001, 1, 0, 4};
    vt[38] = '{4'b1000, 0, 16'h0000, S9, S9, 4'b1000, 0, 0, 4};

    do_reset();

    for (int i = 0; i < 39; i++) begin
      apply(vt[i].ph, vt[i].ld, vt[i].d);
      want_seg = LZB ? vt[i].seg_lzb : vt[i].seg;
      check($sformatf("row%0d seg", i), 32'(seg), 32'(want_seg));
      check($sformatf("row%0d dig", i), 32'(dig), 32'(vt[i].dig));
      check($sformatf("row%0d pending", i), 32'(pending), 32'(vt[i].pend));
      check($sformatf("row%0d seq_err", i), 32'(seq_err), 32'(vt[i].serr));
      check($sformatf("row%0d err_cnt", i), 32'(err_cnt), 32'(vt[i].ecnt));
      check($sformatf("row%0d err_cnt_sat", i), 32'(err_cnt_s), 32'(sat(vt[i].ecnt, 3)));
    end

    // Mid-frame reset, then a frame that starts away from 1000.
    phase = 4'b0100; load = 1'b0;
    do_reset();
    apply(4'b0010, 1'b0, 16'h0);
    check_model("post-reset 0010");
    apply(4'b0001, 1'b0, 16'h0);
    check_model("post-reset 0001");

    // Randomized traffic: mostly in-order phases, some resyncs and garbage.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 15 && m_valid) ph = 4'(1 << m_exp_pos);
      else if (r < 17)       ph = 4'(1 << $urandom_range(0, 3));
      else                   ph = 4'($urandom_range(0, 15));
      ld = ($urandom_range(0, 6) == 0);
      d  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) d[7:4] = 4'h0;
      if (i == 300) begin
        do_reset();
      end
      apply(ph, ld, d);
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
